// File: rtl/cry_pkg.sv
// Shared field layout, latency and colour-format helpers for the CRY->RGB converter.
package cry_pkg;

    localparam int C_HI   = 15;
    localparam int C_LO   = 12;
    localparam int R_HI   = 11;
    localparam int R_LO   = 8;
    localparam int Y_HI   = 7;
    localparam int Y_LO   = 0;

    localparam int R16_HI = 15;
    localparam int R16_LO = 11;
    localparam int B16_HI = 10;
    localparam int B16_LO = 6;
    localparam int G16_HI = 5;
    localparam int G16_LO = 0;

    localparam int CRY_LATENCY = 2;

    // RGB16 keeps the top bits of each 8-bit component
    function automatic logic [15:0] rgb24_to16(input logic [23:0] rgb);
        return {rgb[23:19], rgb[7:3], rgb[15:10]};
    endfunction

    function automatic logic [23:0] rgb16_to24(input logic [15:0] p);
        logic [4:0] r5;
        logic [4:0] b5;
        logic [5:0] g6;
        r5 = p[R16_HI:R16_LO];
        b5 = p[B16_HI:B16_LO];
        g6 = p[G16_HI:G16_LO];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

endpackage

// File: rtl/cry_scale.sv
// One colour component: table value scaled by intensity, floor(tab*y/256).
module cry_scale (
    input  logic [7:0] tab_i,
    input  logic [7:0] y_i,
    output logic [7:0] val_o
);

    assign val_o = 8'(({8'd0, tab_i} * {8'd0, y_i}) >> 8);

endmodule

// File: rtl/cry_rgb_conv.sv
// Two-stage CRY to RGB24/RGB16 converter with external colour ROMs
// and an optional RGB16 bypass.
module cry_rgb_conv
    import cry_pkg::*;
#(
    parameter logic PASS_EN = 1'b1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [15:0] in_pixel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rgb_mode,
    output logic [7:0]  rom_a,
    input  logic [7:0]  rom_r_z,
    input  logic [7:0]  rom_g_z,
    input  logic [7:0]  rom_b_z,
    output logic [23:0] out_rgb,
    output logic [15:0] out_rgb16,
    output logic        out_valid,
    input  logic        out_ready
);

    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_pix_q, s1_pix_d;
    logic        s1_mode_q, s1_mode_d;
    logic        s2_valid_q, s2_valid_d;
    logic [23:0] rgb_q, rgb_d;
    logic [15:0] rgb16_q, rgb16_d;

    logic        in_acc;
    logic        s2_adv;
    logic        s2_load;
    logic [7:0]  sc_r, sc_g, sc_b;
    logic [7:0]  s1_y;

    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign in_acc   = in_valid & in_ready & ~reset;
    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s2_load  = s1_valid_q & s2_adv;
    assign s1_y     = s1_pix_q[Y_HI:Y_LO];

    // Address follows S1 while stalled so ROM data stays paired with it
    assign rom_a = in_acc ? {in_pixel[C_HI:C_LO], in_pixel[R_HI:R_LO]}
                          : {s1_pix_q[C_HI:C_LO], s1_pix_q[R_HI:R_LO]};

    cry_scale u_scale_r (.tab_i(rom_r_z), .y_i(s1_y), .val_o(sc_r));
    cry_scale u_scale_g (.tab_i(rom_g_z), .y_i(s1_y), .val_o(sc_g));
    cry_scale u_scale_b (.tab_i(rom_b_z), .y_i(s1_y), .val_o(sc_b));

    always_comb begin
        s1_pix_d   = s1_pix_q;
        s1_mode_d  = s1_mode_q;
        s1_valid_d = in_acc | (s1_valid_q & ~s2_adv);
        if (in_acc) begin
            s1_pix_d  = in_pixel;
            s1_mode_d = rgb_mode;
        end
    end

    always_comb begin
        rgb_d      = rgb_q;
        rgb16_d    = rgb16_q;
        s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
        if (s2_load) begin
            if (PASS_EN && s1_mode_q) begin
                rgb16_d = s1_pix_q;
                rgb_d   = rgb16_to24(s1_pix_q);
            end else begin
                rgb_d   = {sc_r, sc_g, sc_b};
                rgb16_d = rgb24_to16({sc_r, sc_g, sc_b});
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            rgb_q      <= '0;
            rgb16_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            rgb_q      <= rgb_d;
            rgb16_q    <= rgb16_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_rgb   = rgb_q;
    assign out_rgb16 = rgb16_q;

endmodule

// File: tb/tb_cry_rgb_conv.sv
// Randomised and directed bench for cry_rgb_conv against a queue-based
// arithmetic reference model.
module tb_cry_rgb_conv;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [15:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic        rgb_mode;
    logic [7:0]  rom_a;
    logic [7:0]  rom_r_z, rom_g_z, rom_b_z;
    logic [23:0] out_rgb;
    logic [15:0] out_rgb16;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] expq[$];

    always #5 sys_clk = ~sys_clk;

    always_ff @(posedge sys_clk) begin
        rom_r_z <= rom_a;
        rom_g_z <= ~rom_a;
        rom_b_z <= 8'hFF;
    end

    cry_rgb_conv #(.PASS_EN(1'b1)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rgb_mode (rgb_mode),
        .rom_a    (rom_a),
        .rom_r_z  (rom_r_z),
        .rom_g_z  (rom_g_z),
        .rom_b_z  (rom_b_z),
        .out_rgb  (out_rgb),
        .out_rgb16(out_rgb16),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {rgb16, rgb24} computed directly from the colour rules
    function automatic logic [39:0] model(input logic [15:0] pix,
                                          input logic mode);
        int a, y, r, g, b, r5, g6, b5;
        logic [15:0] p16;
        if (mode) begin
            r5  = int'(pix[15:11]);
            b5  = int'(pix[10:6]);
            g6  = int'(pix[5:0]);
            r   = r5 * 8 + r5 / 4;
            g   = g6 * 4 + g6 / 16;
            b   = b5 * 8 + b5 / 4;
            p16 = pix;
        end else begin
            a   = int'(pix[15:8]);
            y   = int'(pix[7:0]);
            r   = (a * y) / 256;
            g   = ((255 - a) * y) / 256;
            b   = (255 * y) / 256;
            p16 = 16'((r / 8) * 2048 + (b / 8) * 64 + g / 4);
        end
        return {p16, 8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic monitor();
        logic        held_v;
        logic [39:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge sys_clk);
            if (reset) begin
                expq.delete();
                held_v = 1'b0;
            end else begin
                if (held_v)
                    check("hold", {out_valid, out_rgb16, out_rgb},
                          {1'b1, held});
                if (in_valid && in_ready)
                    expq.push_back(model(in_pixel, rgb_mode));
                if (out_valid && out_ready) begin
                    if (expq.size() == 0)
                        check("spurious_out", 48'd1, 48'd0);
                    else
                        check("out", {out_rgb16, out_rgb}, expq.pop_front());
                end
                held_v = out_valid && !out_ready;
                held   = {out_rgb16, out_rgb};
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_one(input logic [15:0] pix, input logic mode,
                            input logic [23:0] e24, input logic [15:0] e16);
        in_valid = 1'b1;
        in_pixel = pix;
        rgb_mode = mode;
        #1 check("acc_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1 check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("rgb24", out_rgb, e24);
        check("rgb16", out_rgb16, e16);
        tick();
    endtask

    initial begin
        int          acc;
        logic [7:0]  a_snap;
        logic [39:0] o_snap;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        rgb_mode  = 1'b0;
        out_ready = 1'b1;

        fork
            monitor();
        join_none

        repeat (3) tick();
        check("rst_state", {out_valid, out_rgb, out_rgb16, rom_a}, 0);
        reset = 1'b0;
        #1 check("rdy_after_rst", in_ready, 1);
        tick();

        send_one(16'h3CFF, 1'b0, 24'h3BC2FE, 16'h3FF0);
        send_one(16'h3C00, 1'b0, 24'h000000, 16'h0000);
        send_one(16'hFFFF, 1'b0, 24'hFE00FE, 16'hFFC0);
        send_one(16'hF81F, 1'b1, 24'hFF7D00, 16'hF81F);

        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_pixel = 16'($urandom);
            rgb_mode = 1'($urandom);
            #1;
            if (i < 8) check("burst_rdy", in_ready, 1);
            tick();
            check("burst_ov", out_valid, (i >= 1 && i <= 8));
        end
        in_valid = 1'b0;

        out_ready = 1'b0;
        acc = 0;
        a_snap = '0;
        o_snap = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pixel = 16'($urandom);
            rgb_mode = 1'b0;
            #1;
            if (in_ready) acc++;
            if (i == 2) begin
                a_snap = rom_a;
                o_snap = {out_rgb16, out_rgb};
            end
            if (i > 2) begin
                check("stall_roma", rom_a, a_snap);
                check("stall_out", {out_rgb16, out_rgb}, o_snap);
                check("stall_rdy", in_ready, 0);
            end
            tick();
        end
        check("stall_acc", acc, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pixel = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("drain1", expq.size(), 0);

        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6 && acc < 2; i++) begin
            in_valid = 1'b1;
            in_pixel = 16'($urandom);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("full_before_rst", {out_valid, in_ready}, 2'b10);
        reset = 1'b1;
        tick();
        check("rst_mid", {out_valid, out_rgb, out_rgb16, rom_a}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1 check("rdy_after_rst2", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale", out_valid, 0);
        end

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_pixel  = 16'($urandom);
            rgb_mode  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("drain2", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
